// File: rtl/write_flash_control.sv
// Write-path page controller: bad-block check, page streaming from the page
// RAM to the flash program buffer, program command and relocation on failure.
module write_flash_control #(
  parameter int unsigned PAGE_BYTES      = 8192,
  parameter int unsigned PAGES_PER_BLOCK = 128,
  parameter int unsigned MAX_RELOCATE    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_write,
  input  logic [23:0] write_addr_row_reg,
  output logic [23:0] write_addr_row,
  output logic        block_check_req,
  input  logic [1:0]  write_addr_row_error,
  output logic [14:0] write_ram_addr,
  output logic        write_en_ram,
  input  logic [7:0]  write_ram_dataout,
  output logic [7:0]  write_data,
  output logic        write_data_valid,
  input  logic        write_data_ready,
  output logic [13:0] write_data_cnt,
  output logic        prog_start,
  input  logic        prog_done,
  input  logic        prog_fail,
  output logic        write_busy,
  output logic        write_done,
  output logic        write_error,
  output logic [3:0]  write_state
);

  localparam int unsigned RW = $clog2(MAX_RELOCATE + 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LATCH = 4'd1,
    S_CHECK = 4'd2,
    S_RELOC = 4'd3,
    S_LOAD  = 4'd4,
    S_PROG  = 4'd5,
    S_PWAIT = 4'd6,
    S_FAIL  = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  state_t        state_q, state_d;
  logic          en_prev_q, en_prev_d;
  logic [23:0]   row_q, row_d;
  logic          err_q, err_d;
  logic [RW-1:0] reloc_q, reloc_d;
  logic [13:0]   cnt_q, cnt_d;
  logic [13:0]   fidx_q, fidx_d;   // next RAM byte index to fetch
  logic          pend_q, pend_d;   // RAM read issued last cycle, data on dataout now
  logic          out_v_q, out_v_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          pf_v_q, pf_v_d;   // prefetch slot behind the output register
  logic [7:0]    pf_data_q, pf_data_d;

  logic          rise;
  logic          acc;
  logic          issue;
  logic [1:0]    occ;
  logic [1:0]    hold;

  // Next-state, datapath and handshake control
  always_comb begin
    state_d    = state_q;
    en_prev_d  = en_write;
    row_d      = row_q;
    err_d      = err_q;
    reloc_d    = reloc_q;
    cnt_d      = cnt_q;
    fidx_d     = fidx_q;
    pend_d     = 1'b0;
    out_v_d    = out_v_q;
    out_data_d = out_data_q;
    pf_v_d     = pf_v_q;
    pf_data_d  = pf_data_q;
    rise       = en_write & ~en_prev_q;
    acc        = 1'b0;
    issue      = 1'b0;
    // Bytes in flight after this cycle's accept; keep it at most two so a
    // returning read always has a slot (output register or prefetch).
    occ        = {1'b0, out_v_q} + {1'b0, pf_v_q} + {1'b0, pend_q};
    hold       = occ - {1'b0, acc};

    case (state_q)
      S_IDLE: if (rise) state_d = S_LATCH;
      S_LATCH: begin
        row_d   = write_addr_row_reg;
        err_d   = 1'b0;
        reloc_d = '0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (write_addr_row_error == 2'd1) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          fidx_d  = '0;
          out_v_d = 1'b0;
          pf_v_d  = 1'b0;
        end else if (write_addr_row_error == 2'd2) begin
          state_d = S_RELOC;
        end
      end
      S_RELOC: begin
        // Adding a whole block keeps the page field and wraps the block field
        row_d   = row_q + 24'(PAGES_PER_BLOCK);
        reloc_d = reloc_q + RW'(1);
        state_d = (reloc_d == RW'(MAX_RELOCATE)) ? S_FAIL : S_CHECK;
      end
      S_LOAD: begin
        acc   = out_v_q & write_data_ready;
        hold  = occ - {1'b0, acc};
        issue = (fidx_q < 14'(PAGE_BYTES)) && (hold < 2'd2);
        pend_d = issue;
        if (issue) fidx_d = fidx_q + 14'd1;
        if (acc) cnt_d = cnt_q + 14'd1;
        if (~out_v_q | write_data_ready) begin
          if (pf_v_q) begin
            out_data_d = pf_data_q;
            out_v_d    = 1'b1;
            pf_v_d     = pend_q;
            if (pend_q) pf_data_d = write_ram_dataout;
          end else if (pend_q) begin
            out_data_d = write_ram_dataout;
            out_v_d    = 1'b1;
          end else begin
            out_v_d = 1'b0;
          end
        end else if (pend_q) begin
          pf_data_d = write_ram_dataout;
          pf_v_d    = 1'b1;
        end
        if (acc && (cnt_q == 14'(PAGE_BYTES - 1))) begin
          state_d = S_PROG;
          out_v_d = 1'b0;
          pf_v_d  = 1'b0;
          pend_d  = 1'b0;
        end
      end
      S_PROG: state_d = S_PWAIT;
      S_PWAIT: begin
        if (prog_done) state_d = prog_fail ? S_RELOC : S_DONE;
      end
      S_FAIL: begin
        err_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; the edge detector resets high so a request
  // line already held high across reset is not taken as a new request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      en_prev_q  <= 1'b1;
      row_q      <= '0;
      err_q      <= 1'b0;
      reloc_q    <= '0;
      cnt_q      <= '0;
      fidx_q     <= '0;
      pend_q     <= 1'b0;
      out_v_q    <= 1'b0;
      out_data_q <= '0;
      pf_v_q     <= 1'b0;
      pf_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      en_prev_q  <= en_prev_d;
      row_q      <= row_d;
      err_q      <= err_d;
      reloc_q    <= reloc_d;
      cnt_q      <= cnt_d;
      fidx_q     <= fidx_d;
      pend_q     <= pend_d;
      out_v_q    <= out_v_d;
      out_data_q <= out_data_d;
      pf_v_q     <= pf_v_d;
      pf_data_q  <= pf_data_d;
    end
  end

  // Output decode
  always_comb begin
    write_addr_row   = row_q;
    block_check_req  = (state_q == S_CHECK);
    write_ram_addr   = {2'b00, fidx_q[12:0]};
    write_en_ram     = issue;
    write_data       = out_data_q;
    write_data_valid = out_v_q;
    write_data_cnt   = cnt_q;
    prog_start       = (state_q == S_PROG);
    write_busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    write_done       = (state_q == S_DONE);
    write_error      = err_q;
    write_state      = state_q;
  end

endmodule

// File: tb/tb_write_flash_control.sv
// Bench for write_flash_control: page RAM model, bad-block and program
// responders, and a transaction-level scoreboard checked every cycle.
module tb_write_flash_control;
  localparam int P   = 8192;
  localparam int MAXR = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_write;
  logic [23:0] write_addr_row_reg;
  logic [23:0] write_addr_row;
  logic        block_check_req;
  logic [1:0]  write_addr_row_error;
  logic [14:0] write_ram_addr;
  logic        write_en_ram;
  logic [7:0]  write_ram_dataout;
  logic [7:0]  write_data;
  logic        write_data_valid;
  logic        write_data_ready;
  logic [13:0] write_data_cnt;
  logic        prog_start;
  logic        prog_done;
  logic        prog_fail;
  logic        write_busy;
  logic        write_done;
  logic        write_error;
  logic [3:0]  write_state;

  write_flash_control #(.PAGE_BYTES(P), .PAGES_PER_BLOCK(128), .MAX_RELOCATE(MAXR)) dut (
    .clk(clk), .rst(rst), .en_write(en_write),
    .write_addr_row_reg(write_addr_row_reg), .write_addr_row(write_addr_row),
    .block_check_req(block_check_req), .write_addr_row_error(write_addr_row_error),
    .write_ram_addr(write_ram_addr), .write_en_ram(write_en_ram),
    .write_ram_dataout(write_ram_dataout), .write_data(write_data),
    .write_data_valid(write_data_valid), .write_data_ready(write_data_ready),
    .write_data_cnt(write_data_cnt), .prog_start(prog_start), .prog_done(prog_done),
    .prog_fail(prog_fail), .write_busy(write_busy), .write_done(write_done),
    .write_error(write_error), .write_state(write_state)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Page RAM with one-cycle registered read
  logic [7:0] mem [P];
  initial for (int i = 0; i < P; i++) mem[i] = 8'(i * 37 + i / 256 + 90);
  always @(posedge clk) if (write_en_ram) write_ram_dataout <= mem[write_ram_addr[12:0]];

  // Responder configuration and counters
  int          err_resp_q[$];
  bit          fail_resp_q[$];
  logic [23:0] exp_row_q[$];
  bit          bp_mode = 1'b0;
  int          n_lookups = 0, n_bad = 0, n_failr = 0, n_prog = 0, n_done = 0;
  int          lk_delay = 1, pd_timer = 0;

  // Flash-side responders, updated well after the clock edge
  always @(posedge clk) begin
    #2;
    if (rst) begin
      write_addr_row_error = 2'd0;
      prog_done = 1'b0;
      prog_fail = 1'b0;
      lk_delay = 1;
      pd_timer = 0;
      write_data_ready = 1'b1;
    end else begin
      write_data_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (write_addr_row_error != 2'd0) write_addr_row_error = 2'd0;
      else if (block_check_req) begin
        if (lk_delay != 0) lk_delay--;
        else begin
          int v;
          v = (err_resp_q.size() != 0) ? err_resp_q.pop_front() : 1;
          write_addr_row_error = 2'(v);
          lk_delay = 1;
          n_lookups++;
          if (v == 2) n_bad++;
        end
      end
      prog_done = 1'b0;
      prog_fail = 1'b0;
      if (prog_start) pd_timer = 5;
      else if (pd_timer != 0) begin
        pd_timer--;
        if (pd_timer == 0) begin
          prog_done = 1'b1;
          prog_fail = (fail_resp_q.size() != 0) ? fail_resp_q.pop_front() : 1'b0;
          if (prog_fail) n_failr++;
        end
      end
    end
  end

  // Scoreboard: expected byte stream is the RAM page in order, once per LOAD
  logic [3:0] st;
  bit         in_load = 0, prev_stall = 0, first_seen = 0;
  logic [7:0] prev_data;
  int         load_cyc = 0, exp_idx = 0;
  always @(negedge clk) begin
    if (rst) begin
      in_load = 0;
      prev_stall = 0;
    end else begin
      st = write_state;
      chk("check_req", block_check_req, st == 4'd2);
      chk("busy", write_busy, st != 4'd0 && st != 4'd8);
      chk("done", write_done, st == 4'd8);
      chk("prog_pulse", prog_start, st == 4'd5);
      if (st != 4'd4) begin
        chk("ram_en_outside_load", write_en_ram, 0);
        chk("valid_outside_load", write_data_valid, 0);
        in_load = 0;
        prev_stall = 0;
      end else begin
        if (!in_load) begin
          in_load = 1; load_cyc = 0; exp_idx = 0; first_seen = 0;
        end else load_cyc++;
        chk("byte_cnt", write_data_cnt, exp_idx);
        if (prev_stall) begin
          chk("stall_valid", write_data_valid, 1);
          chk("stall_data", write_data, prev_data);
        end
        if (write_data_valid && !first_seen) begin
          first_seen = 1;
          chk("first_valid_latency", load_cyc, 2);
        end
        if (write_en_ram) chk("ram_addr_hi", write_ram_addr[14:13], 0);
        if (write_data_valid && write_data_ready) begin
          if (exp_idx >= P) begin
            nchk++; nerr++;
            $display("FAIL extra_byte: actual=index %0d required=below %0d", exp_idx, P);
          end else chk("byte", write_data, mem[exp_idx]);
          exp_idx++;
          if (exp_idx == P && !bp_mode) chk("last_accept_cycle", load_cyc, P + 1);
        end
        prev_stall = write_data_valid && !write_data_ready;
        prev_data = write_data;
      end
      if (prog_start) begin
        n_prog++;
        chk("page_complete", exp_idx, P);
        chk("cnt_at_prog", write_data_cnt, P);
        if (exp_row_q.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_prog_start: actual=row 0x%0h required=no program", write_addr_row);
        end else chk("prog_row", write_addr_row, exp_row_q.pop_front());
      end
      if (write_done) n_done++;
    end
  end

  // One request from rising edge to completion, checked against the
  // relocation rule: final row = start + 128 * relocations, error iff MAXR reached
  task automatic run_req(input string nm, input logic [23:0] row, input int exp_progs,
                         input bit exp_err, input logic [23:0] exp_final);
    int p0, d0, b0, f0, l0, cyc, relocs;
    p0 = n_prog; d0 = n_done; b0 = n_bad; f0 = n_failr; l0 = n_lookups; cyc = 0;
    write_addr_row_reg = row;
    en_write = 1'b1;
    @(negedge clk);
    while (!write_done && cyc < 40000) begin @(negedge clk); cyc++; end
    if (!write_done) begin
      nchk++; nerr++;
      $display("FAIL %s_timeout: actual=no write_done required=write_done within 40000 cycles", nm);
    end
    @(negedge clk);
    relocs = (n_bad - b0) + (n_failr - f0);
    chk({nm, "_error"}, write_error, exp_err);
    chk({nm, "_error_model"}, write_error, relocs >= MAXR);
    chk({nm, "_row"}, write_addr_row, exp_final);
    chk({nm, "_row_model"}, write_addr_row, 24'(row + 24'(128 * relocs)));
    chk({nm, "_progs"}, n_prog - p0, exp_progs);
    chk({nm, "_done_pulses"}, n_done - d0, 1);
    chk({nm, "_idle"}, write_state, 0);
    chk({nm, "_lookups"}, n_lookups - l0, (n_bad - b0) + exp_progs);
    en_write = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    en_write = 1'b0;
    write_addr_row_reg = '0;
    write_data_ready = 1'b1;
    write_addr_row_error = 2'd0;
    prog_done = 1'b0;
    prog_fail = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", write_state, 0);
    chk("rst_row", write_addr_row, 0);
    chk("rst_cnt", write_data_cnt, 0);
    chk("rst_flags", {block_check_req, write_en_ram, write_data_valid, prog_start,
                      write_busy, write_done, write_error}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Good block, full rate
    err_resp_q = {1}; exp_row_q = {24'h000105};
    run_req("good", 24'h000105, 1, 1'b0, 24'h000105);
    chk("good_final_cnt", write_data_cnt, P);

    // Random backpressure
    bp_mode = 1'b1;
    err_resp_q = {1}; exp_row_q = {24'h000105};
    run_req("backpressure", 24'h000105, 1, 1'b0, 24'h000105);
    chk("bp_final_cnt", write_data_cnt, P);
    bp_mode = 1'b0;

    // Bad block skipped once
    err_resp_q = {2, 1}; exp_row_q = {24'h000285};
    run_req("badskip", 24'h000205, 1, 1'b0, 24'h000285);

    // Program fails once, retried in the next block
    err_resp_q = {1, 1}; fail_resp_q = {1'b1, 1'b0}; exp_row_q = {24'h000305, 24'h000385};
    run_req("progretry", 24'h000305, 2, 1'b0, 24'h000385);

    // Every block bad: relocation budget exhausted
    err_resp_q = {2, 2, 2, 2, 2}; exp_row_q = {};
    run_req("exhaust", 24'h000405, 0, 1'b1, 24'h000605);
    err_resp_q = {};

    // Reset during LOAD at byte 3000
    err_resp_q = {1}; exp_row_q = {};
    write_addr_row_reg = 24'h000105;
    en_write = 1'b1;
    cyc = 0;
    while (!(in_load && exp_idx >= 3000) && cyc < 20000) begin @(negedge clk); cyc++; end
    chk("reached_byte_3000", exp_idx, 3000);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_state", write_state, 0);
    chk("midrst_row", write_addr_row, 0);
    chk("midrst_cnt", write_data_cnt, 0);
    chk("midrst_flags", {block_check_req, write_en_ram, write_data_valid, prog_start,
                         write_busy, write_done, write_error, write_data}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc = n_prog;
    repeat (20) @(negedge clk);
    chk("held_en_no_action_state", write_state, 0);
    chk("held_en_no_busy", write_busy, 0);
    chk("held_en_no_prog", n_prog - cyc, 0);
    en_write = 1'b0;
    repeat (2) @(negedge clk);
    err_resp_q = {1}; exp_row_q = {24'h000105};
    run_req("after_rst", 24'h000105, 1, 1'b0, 24'h000105);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/write_flash_control.md
Name: write_flash_control

Overview:
Write-path page controller for the NAND flash subsystem, the transmit-side counterpart of the page read controller. On a rising edge of en_write it checks the target block's bad-block status and skips bad blocks. It then streams one 8192-byte page from the shared page RAM to the low-level flash program interface using a valid/ready handshake, and issues the program command. On program failure it relocates the write to the next block and retries, then reports done or error.

Parameters:
PAGE_BYTES, 8192, bytes streamed per page (power of two, ≤ 8192)
PAGES_PER_BLOCK, 128, pages per erase block; row[6:0] is the page-in-block field
MAX_RELOCATE, 4, maximum block skips/relocations per request before write_error

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
en_write  in  1  write request; the action starts on its rising edge
write_addr_row_reg  in  24  requested row address
write_addr_row  out  24  row address presented to the flash layer
block_check_req  out  1  request bad-block lookup for write_addr_row
write_addr_row_error  in  2  0 = not checked, 1 = good block, 2 = bad block
write_ram_addr  out  15  page RAM read address
write_en_ram  out  1  page RAM read enable (read-only; 1-cycle registered latency)
write_ram_dataout  in  8  page RAM read data
write_data  out  8  byte to flash program buffer
write_data_valid  out  1  write_data is valid
write_data_ready  in  1  flash layer accepts a byte
write_data_cnt  out  14  number of bytes accepted so far
prog_start  out  1  one-cycle program command pulse
prog_done  in  1  one-cycle pulse: program finished
prog_fail  in  1  program status; sampled when prog_done is high
write_busy  out  1  high from the cycle after the rising edge until DONE
write_done  out  1  one-cycle completion pulse
write_error  out  1  sticky failure flag; cleared on the next accepted request
write_state  out  4  current state encoding

Behaviour:
- Reset values: all outputs 0; state IDLE; relocation counter 0.
- A rising edge is en_write & ~en_write_d, where en_write_d is a registered copy of en_write. Rising edges outside IDLE are ignored.
- State encodings:
  - 0 IDLE: wait for a rising edge, then go to LATCH.
  - 1 LATCH: write_addr_row <= write_addr_row_reg; clear write_error and the relocation counter; go to CHECK.
  - 2 CHECK: block_check_req = 1 until write_addr_row_error != 0. Value 1 → LOAD. Value 2 → RELOC.
  - 3 RELOC: write_addr_row[23:7] += 1 and write_addr_row[6:0] is kept; the increment wraps modulo 2^17. The relocation counter increments. If the counter reaches MAX_RELOCATE → FAIL, else → CHECK.
  - 4 LOAD: stream bytes 0..PAGE_BYTES-1.
    - write_ram_addr[14:13] = 0 and [12:0] = byte index.
    - A prefetch register hides the RAM latency. The first write_data_valid is asserted 2 cycles after entering LOAD.
    - With write_data_ready held high, one byte transfers per cycle; the last byte is accepted on cycle PAGE_BYTES+1 after entry.
    - While write_data_valid & ~write_data_ready, write_data and write_data_valid hold stable. No byte is dropped or duplicated, and the RAM is not read ahead by more than one byte.
    - write_data_cnt increments on each accepted byte. Once it reaches PAGE_BYTES, write_data_valid drops the next cycle → PROG.
  - 5 PROG: prog_start pulses for exactly 1 cycle → PWAIT.
  - 6 PWAIT: wait for prog_done.
    - prog_done with prog_fail = 0 → DONE.
    - prog_done with prog_fail = 1 → RELOC. The page data is re-streamed from RAM byte 0; the RAM is never modified.
  - 7 FAIL: write_error <= 1 → DONE.
  - 8 DONE: write_done pulses 1 cycle; write_busy drops → IDLE.
- write_data_cnt is reset to 0 on entering LOAD and holds its value elsewhere.
- write_en_ram is high only in LOAD while fetching.
- If prog_done arrives outside PWAIT, it is ignored.
- If write_addr_row_error reads 0 in CHECK, the block keeps waiting; there is no timeout.
- Asynchronous rst mid-operation returns everything to reset values immediately. No prog_start is issued after reset release until a new rising edge.

Test Plan:
- Good block, ready always 1: row 0x000105, error = 1 → write_addr_row = 0x000105, 8192 bytes equal to RAM[0..8191] in consecutive cycles, one prog_start pulse; prog_done with fail = 0 → write_done, write_error = 0.
- Backpressure: toggle write_data_ready randomly at 50% → byte sequence still matches RAM exactly, write_data_cnt ends at 8192, data is stable during stalls.
- Bad block skip: row 0x000205, first lookup returns 2 and the second returns 1 → page is programmed at row 0x000285, relocation count 1.
- Program fail then pass: first prog_done arrives with fail = 1 → row advances by 128, data is re-streamed from byte 0, second program passes → write_done, write_error = 0.
- Exhaustion: lookup always returns 2 with MAX_RELOCATE = 4 → no prog_start is issued, write_error = 1, write_done pulses once.
- Reset mid-LOAD at byte 3000 → all outputs go to 0 immediately; en_write held high after reset produces no action until it falls and rises again.
